data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 152 +++++++++++++++
 tb/tb_data_mem.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-addressable data memory with sized, aligned load/store and fixed access latency
module data_mem #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] adr,
  input  logic [31:0]       din,
  output logic              busy,
  output logic              done,
  output logic [31:0]       dout,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, commit;

  logic              a_we, a_uns;
  logic [1:0]        a_size;
  logic [ADDR_W-1:0] a_adr;
  logic [31:0]       a_din;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [1:0]        lane;
  logic              fault;
  logic [31:0]       rword, wword, load_val;
  logic [3:0]        be;
  logic [7:0]        bsel;
  logic [15:0]       hsel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign word_idx = {2'b00, a_adr[ADDR_W-1:2]};
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign lane     = a_adr[1:0];
  assign rword    = mem[mem_idx];

  // Out-of-range indices are caught here, so mem_idx never addresses past DEPTH on a real access.
  assign fault = (a_size == 2'b11)
              || (a_size == 2'b01 && a_adr[0])
              || (a_size == 2'b10 && lane != 2'b00)
              || (word_idx >= ADDR_W'(DEPTH));

  always_comb begin
    be    = 4'b0000;
    wword = 32'd0;
    case (a_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{a_din[7:0]}};
      end
      2'b01: begin
        be    = a_adr[1] ? 4'b1100 : 4'b0011;
        wword = {2{a_din[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = a_din;
      end
    endcase
  end

  always_comb begin
    bsel     = rword[{lane, 3'b000} +: 8];
    hsel     = rword[{a_adr[1], 4'b0000} +: 16];
    load_val = rword;
    case (a_size)
      2'b00:   load_val = a_uns ? {24'd0, bsel} : {{24{bsel[7]}}, bsel};
      2'b01:   load_val = a_uns ? {16'd0, hsel} : {{16{hsel[15]}}, hsel};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done    <= 1'b0;
      err     <= 1'b0;
      dout    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= commit;
      err     <= commit && fault;
      // Successful stores leave dout holding the previous load result.
      if (commit && (fault || !a_we)) begin
        dout <= fault ? 32'd0 : load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      a_we   <= we;
      a_size <= size;
      a_uns  <= uns;
      a_adr  <= adr;
      a_din  <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && commit && a_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[mem_idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - randomized and directed checks of data_mem at latencies 0, 1, 4 and 15
module tb_data_mem;

  localparam int DEPTH = 32;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req, we, uns;
  logic [1:0]    size;
  logic [AW-1:0] adr;
  logic [31:0]   din;
  logic [1:0]    sel;

  logic          busy_a [4];
  logic          done_a [4];
  logic          err_a  [4];
  logic [31:0]   dout_a [4];
  logic          busy_w, done_w, err_w;
  logic [31:0]   dout_w;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (AW),
      .LATENCY((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 4 : 15)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req && (sel == 2'(g))),
      .we   (we),
      .size (size),
      .uns  (uns),
      .adr  (adr),
      .din  (din),
      .busy (busy_a[g]),
      .done (done_a[g]),
      .dout (dout_a[g]),
      .err  (err_a[g])
    );
  end

  assign busy_w = busy_a[sel];
  assign done_w = done_a[sel];
  assign err_w  = err_a[sel];
  assign dout_w = dout_a[sel];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 4;
      default: return 15;
    endcase
  endfunction

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL %s: got %h expected %h (lat %0d, t=%0t)", name, act_v, exp_v, lat_of(int'(sel)), $time);
    end
  endtask

  // Reference model: a flat byte array per instance plus edge-count timing of the one access in flight.
  logic [7:0]    mem_m [4][4*DEPTH];
  int            n = 0;
  bit            act = 1'b0;
  int            e0 = 0;
  int            mlat = 0;
  bit            p_we, p_uns;
  logic [1:0]    p_size;
  logic [AW-1:0] p_adr;
  logic [31:0]   p_din;
  bit            exp_done = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  logic [31:0]   exp_dout = 32'd0;

  function automatic void model_commit();
    int          ba, nb;
    bit          f;
    logic [31:0] v;
    ba = int'(p_adr);
    nb = 1 << p_size;
    f  = (p_size == 2'd3) || (p_size == 2'd1 && ba % 2 != 0) ||
         (p_size == 2'd2 && ba % 4 != 0) || (ba / 4 >= DEPTH);
    exp_done = 1'b1;
    if (f) begin
      exp_err  = 1'b1;
      exp_dout = 32'd0;
    end else if (p_we) begin
      for (int i = 0; i < nb; i++) mem_m[sel][ba + i] = p_din[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_m[sel][ba + i]) << (8*i));
      if (!p_uns && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8*nb));
      exp_dout = v;
    end
  endfunction

  always @(posedge clk) begin
    bit idle;
    n++;
    idle     = !act;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!rst_n) begin
      act      = 1'b0;
      exp_dout = 32'd0;
    end else begin
      if (act && n == e0 + mlat + 1) model_commit();
      if (act && n == e0 + mlat + 2) act = 1'b0;
      if (idle && req) begin
        act    = 1'b1;
        e0     = n;
        mlat   = lat_of(int'(sel));
        p_we   = we;
        p_size = size;
        p_uns  = uns;
        p_adr  = adr;
        p_din  = din;
      end
    end
    exp_busy = act;
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("done", 32'(done_w), 32'(exp_done));
      chk("busy", 32'(busy_w), 32'(exp_busy));
      chk("dout", dout_w, exp_dout);
      if (exp_done) chk("err", 32'(err_w), 32'(exp_err));
    end
  end

  task automatic wait_idle();
    for (int t = 0; t < 100 && busy_w; t++) @(negedge clk);
    if (busy_w) chk("idle_timeout", 32'(busy_w), 32'd0);
  endtask

  task automatic do_acc(input bit w, input logic [1:0] sz, input bit u, input logic [AW-1:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic re, output int lc);
    wait_idle();
    we = w; size = sz; uns = u; adr = a; din = d; req = 1'b1;
    rd = 32'd0; re = 1'b0; lc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (done_w) begin
        lc = k; rd = dout_w; re = err_w;
        break;
      end
    end
    if (lc == 0) chk("done_timeout", 32'(done_w), 32'd1);
  endtask

  task automatic rand_op(output bit w, output logic [1:0] sz, output bit u,
                         output logic [AW-1:0] a, output logic [31:0] d);
    int r;
    r  = $urandom_range(0, 9);
    sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
    w  = 1'($urandom_range(0, 1));
    u  = 1'($urandom_range(0, 1));
    a  = AW'($urandom_range(0, 4*DEPTH + 7));
    d  = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]   rd, rd2;
    logic          re;
    int            lc, L, nd;
    bit            rw, ru;
    logic [1:0]    rs;
    logic [AW-1:0] ra;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    adr = '0; din = 32'd0; sel = 2'd0;

    for (int k = 0; k < 4; k++) begin
      L = lat_of(k);
      @(negedge clk); checking = 1'b0; rst_n = 1'b0;
      @(negedge clk); sel = 2'(k);
      @(negedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(busy_w), 32'd0);
      chk("reset_done", 32'(done_w), 32'd0);
      chk("reset_dout", dout_w, 32'd0);
      rst_n = 1'b1; checking = 1'b1;

      for (int w = 0; w < DEPTH; w++) do_acc(1'b1, 2'd2, 1'b0, AW'(4*w), 32'd0, rd, re, lc);

      do_acc(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, rd, re, lc);
      chk("st_latency", 32'(lc), 32'(L + 2));
      do_acc(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, rd, re, lc);
      chk("ld_word", rd, 32'hDEAD_BEEF);
      chk("ld_word_err", 32'(re), 32'd0);
      chk("ld_latency", 32'(lc), 32'(L + 2));

      do_acc(1'b1, 2'd2, 1'b0, 12'h010, 32'd0, rd, re, lc);
      do_acc(1'b1, 2'd0, 1'b0, 12'h011, 32'h0000_0080, rd, re, lc);
      do_acc(1'b0, 2'd0, 1'b0, 12'h011, 32'd0, rd, re, lc);
      chk("ld_sbyte", rd, 32'hFFFF_FF80);
      do_acc(1'b0, 2'd0, 1'b1, 12'h011, 32'd0, rd, re, lc);
      chk("ld_ubyte", rd, 32'h0000_0080);
      do_acc(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, rd, re, lc);
      chk("ld_word_after_byte", rd, 32'h0000_8000);

      do_acc(1'b1, 2'd2, 1'b0, 12'h004, 32'hA5A5_5A5A, rd, re, lc);
      do_acc(1'b0, 2'd1, 1'b0, 12'h003, 32'd0, rd, re, lc);
      chk("fault_half_err", 32'(re), 32'd1);
      chk("fault_half_dout", rd, 32'd0);
      do_acc(1'b1, 2'd2, 1'b0, 12'h006, 32'hFFFF_FFFF, rd, re, lc);
      chk("fault_wstore_err", 32'(re), 32'd1);
      do_acc(1'b1, 2'd3, 1'b0, 12'h004, 32'd0, rd, re, lc);
      chk("fault_size3_err", 32'(re), 32'd1);
      do_acc(1'b0, 2'd2, 1'b0, AW'(4*DEPTH), 32'd0, rd, re, lc);
      chk("fault_range_err", 32'(re), 32'd1);
      chk("fault_range_dout", rd, 32'd0);
      do_acc(1'b0, 2'd2, 1'b0, 12'h004, 32'd0, rd, re, lc);
      chk("mem_after_faults", rd, 32'hA5A5_5A5A);
      chk("mem_after_faults_err", 32'(re), 32'd0);

      if (L >= 2) begin
        wait_idle();
        we = 1'b1; size = 2'd2; uns = 1'b0; adr = 12'h020; din = 32'h1234_5678; req = 1'b1;
        @(negedge clk); req = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("wait_reset_done", 32'(done_w), 32'd0);
        chk("wait_reset_busy", 32'(busy_w), 32'd0);
        chk("wait_reset_dout", dout_w, 32'd0);
        rst_n = 1'b1;
        do_acc(1'b0, 2'd2, 1'b0, 12'h020, 32'd0, rd, re, lc);
        chk("discarded_store", rd, 32'd0);
        do_acc(1'b1, 2'd2, 1'b0, 12'h020, 32'd0, rd, re, lc);
        do_acc(1'b0, 2'd2, 1'b0, 12'h020, 32'd0, rd, re, lc);
        chk("store_zero_reload", rd, 32'd0);
      end

      wait_idle();
      nd = 0;
      for (int i = 0; i < 20; i++) begin
        rand_op(rw, rs, ru, ra, rd2);
        we = rw; size = rs; uns = ru; adr = ra; din = rd2; req = 1'b1;
        @(negedge clk);
        if (done_w) nd++;
      end
      req = 1'b0;
      for (int t = 0; t < 40 && busy_w; t++) begin
        @(negedge clk);
        if (done_w) nd++;
      end
      chk("burst_accepts", 32'(nd), 32'(19 / (L + 3) + 1));

      for (int i = 0; i < 50; i++) begin
        rand_op(rw, rs, ru, ra, rd2);
        do_acc(rw, rs, ru, ra, rd2, rd, re, lc);
        chk("rnd_latency", 32'(lc), 32'(L + 2));
      end
      wait_idle();
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
